// File: rtl/if_pkg.sv
//------------------------------------------------------------------------------
// Module   : if_pkg
// Purpose  : Shared types and constants for the instruction-fetch stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } if_state_e;

    localparam logic [31:0] C_NOP      = 32'h0000_0000;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/if_pc_gen.sv
//------------------------------------------------------------------------------
// Module   : if_pc_gen
// Purpose  : Program counter register, +4 incrementer and redirect mux.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_pc_gen
    import if_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = C_RESET_PC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              pend_i,
    input  logic [ADDR_W-1:0] pend_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o
);

    localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    // A fresh branch beats an older pending redirect, which beats sequential flow.
    always_comb begin
        pc_plus4_o = pc_q + ADDR_W'(4);
        pc_d       = pc_q;
        if (branch_i) begin
            pc_d = branch_target_i & C_ALIGN_MASK;
        end else if (pend_i) begin
            pc_d = pend_target_i & C_ALIGN_MASK;
        end else if (inc_i) begin
            pc_d = pc_plus4_o;
        end
    end

    assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
//------------------------------------------------------------------------------
// Module   : if_fetch
// Purpose  : Instruction fetch stage with stall hold and branch redirect.
//            Optional perf counters enabled by defining IF_PERF_CNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [ADDR_W-1:0] imem_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] inst_o,
    output logic              ifid_write_o,
    output logic              flush_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ~ADDR_W'(3);

    if_state_e         state_d;
    if_state_e         state_q;
    logic              pend_valid_d;
    logic              pend_valid_q;
    logic [ADDR_W-1:0] pend_target_d;
    logic [ADDR_W-1:0] pend_target_q;
    logic [ADDR_W-1:0] hold_d;
    logic [ADDR_W-1:0] hold_q;

    logic              w_pc_inc;
    logic              w_pc_branch;
    logic              w_pc_pend;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_plus4;

    if_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .inc_i           (w_pc_inc),
        .branch_i        (w_pc_branch),
        .branch_target_i (branch_target_i),
        .pend_i          (w_pc_pend),
        .pend_target_i   (pend_target_q),
        .pc_o            (w_pc),
        .pc_plus4_o      (w_pc_plus4)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            hold_q        <= hold_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        hold_d        = hold_q;
        w_pc_inc      = 1'b0;
        w_pc_branch   = 1'b0;
        w_pc_pend     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (branch_taken_i) begin
                    // Without ack the bus must keep its address, so park the target.
                    if (imem_ack_i) begin
                        w_pc_branch  = 1'b1;
                        pend_valid_d = 1'b0;
                    end else begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = branch_target_i & C_ALIGN_MASK;
                    end
                end else if (imem_ack_i) begin
                    if (pend_valid_q) begin
                        w_pc_pend    = 1'b1;
                        pend_valid_d = 1'b0;
                    end else if (stall_i) begin
                        hold_d  = imem_data_i;
                        state_d = ST_HOLD;
                    end else begin
                        w_pc_inc = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_taken_i) begin
                    w_pc_branch = 1'b1;
                    state_d     = ST_FETCH;
                end else if (!stall_i) begin
                    w_pc_inc = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are forced low while rst_i is high so a reset-cycle ack is invisible.
    always_comb begin
        imem_req_o   = 1'b0;
        imem_addr_o  = '0;
        ifid_write_o = 1'b0;
        flush_o      = 1'b0;
        inst_o       = ADDR_W'(C_NOP);
        pc_o         = '0;
        if (!rst_i) begin
            imem_addr_o = w_pc;
            case (state_q)
                ST_FETCH: begin
                    imem_req_o = 1'b1;
                    flush_o    = branch_taken_i;
                    if (imem_ack_i && !branch_taken_i && !pend_valid_q && !stall_i) begin
                        ifid_write_o = 1'b1;
                        inst_o       = imem_data_i;
                        pc_o         = w_pc_plus4;
                    end
                end
                ST_HOLD: begin
                    flush_o = branch_taken_i;
                    if (!branch_taken_i && !stall_i) begin
                        ifid_write_o = 1'b1;
                        inst_o       = hold_q;
                        pc_o         = w_pc_plus4;
                    end
                end
                default: begin
                    imem_req_o = 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_d;
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, ifid_write_o};
        stall_cnt_d = stall_cnt_q + {31'd0, (stall_i && (state_q != ST_IDLE))};
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
//------------------------------------------------------------------------------
// Module   : tb_if_fetch
// Purpose  : Self-checking bench for if_fetch against a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic [31:0] pco;
    logic [31:0] inst;
    logic        wr;
    logic        flush;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: whether a fetch is live, whether a word is parked, redirect target list.
    logic [31:0] m_pc;
    bit          m_live;
    bit          m_parked;
    logic [31:0] m_parked_word;
    logic [31:0] m_redirects[$];

    if_fetch u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .branch_taken_i  (br),
        .branch_target_i (br_tgt),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_ack_i      (ack),
        .imem_data_i     (data),
        .pc_o            (pco),
        .inst_o          (inst),
        .ifid_write_o    (wr),
        .flush_o         (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] next_word(input logic [31:0] a);
        longint unsigned s;
        s = (longint'(a) + 4) % 64'h1_0000_0000;
        return s[31:0];
    endfunction

    task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t,
                        input bit a, input logic [31:0] d);
        bit          e_req;
        bit          e_wr;
        bit          e_fl;
        logic [31:0] e_inst;
        logic [31:0] e_pco;
        logic [31:0] aligned;
        @(negedge clk);
        rst = r; stall = s; br = b; br_tgt = t; ack = a; data = d;
        #1;
        aligned = t & 32'hFFFF_FFFC;
        e_req = 1'b0; e_wr = 1'b0; e_fl = 1'b0; e_inst = 32'h0; e_pco = 32'h0;
        if (r) begin
            check("rst_addr", addr, 32'h0);
            check("rst_pc_o", pco, 32'h0);
            check("rst_inst", inst, 32'h0);
            m_pc = 32'h0; m_live = 1'b0; m_parked = 1'b0; m_redirects.delete();
        end else if (!m_live) begin
            m_live = 1'b1;
        end else if (m_parked) begin
            if (b) begin
                e_fl = 1'b1; m_pc = aligned; m_parked = 1'b0;
            end else if (!s) begin
                e_wr = 1'b1; e_inst = m_parked_word; e_pco = next_word(m_pc);
                m_pc = next_word(m_pc); m_parked = 1'b0;
            end
        end else begin
            e_req = 1'b1;
            check("addr", addr, m_pc);
            if (b) begin
                e_fl = 1'b1;
                if (a) begin m_pc = aligned; m_redirects.delete(); end
                else m_redirects.push_back(aligned);
            end else if (a) begin
                if (m_redirects.size() > 0) begin
                    m_pc = m_redirects[$]; m_redirects.delete();
                end else if (s) begin
                    m_parked = 1'b1; m_parked_word = d;
                end else begin
                    e_wr = 1'b1; e_inst = d; e_pco = next_word(m_pc); m_pc = next_word(m_pc);
                end
            end
        end
        check("req", {31'd0, req}, {31'd0, e_req});
        check("ifid_write", {31'd0, wr}, {31'd0, e_wr});
        check("flush", {31'd0, flush}, {31'd0, e_fl});
        if (e_wr) begin
            check("inst", inst, e_inst);
            check("pc_o", pco, e_pco);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; br_tgt = 32'h0; ack = 1'b0; data = 32'h0;
        m_pc = 32'h0; m_live = 1'b0; m_parked = 1'b0; m_parked_word = 32'h0;
        // reset, with an ack arriving during reset
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'hDEAD_0000);
        // sequential fetch 0,4,8,C
        step(0, 0, 0, 0, 1, 32'hA000_0000);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 32'hA000_0001 + i);
        // stall three cycles at pc 0x10
        step(0, 1, 0, 0, 1, 32'h1111_0010);
        step(0, 1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 1, 32'hBAD0_0000);
        step(0, 0, 0, 0, 0, 32'h0);
        // branch to 0x40 while stalled in hold
        step(0, 1, 0, 0, 1, 32'h2222_0014);
        step(0, 1, 1, 32'h40, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h3333_0040);
        // redirect to 0x80 with ack delayed three cycles
        step(0, 0, 1, 32'h83, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'hBAD0_0001);
        step(0, 0, 0, 0, 1, 32'h4444_0080);
        // two redirects while pending: newest wins
        step(0, 0, 1, 32'h100, 0, 32'h0);
        step(0, 0, 1, 32'h200, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'hBAD0_0002);
        step(0, 0, 0, 0, 1, 32'h5555_0200);
        // wrap from 0xFFFF_FFFC
        step(0, 0, 1, 32'hFFFF_FFFF, 1, 32'h0);
        step(0, 0, 0, 0, 1, 32'h6666_FFFC);
        step(0, 0, 0, 0, 1, 32'h7777_0000);
        // reset during an outstanding request
        step(0, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 1, 32'hBAD0_0003);
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h8888_0000);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 11) == 0),
                 $urandom(),
                 ($urandom_range(0, 9) < 6),
                 $urandom());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
